// File: rtl/jk_pkg.sv
// Shared encodings and the per-bit JK next-state rule for the JK register bank.
package jk_pkg;

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  localparam int TCNT_W = 16;

  // Classic JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   jk_next = q;
      2'b01:   jk_next = 1'b0;
      2'b10:   jk_next = 1'b1;
      default: jk_next = ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_reg_bank_if.sv
// Control and status bundle of jk_reg_bank; master drives controls, slave is the bank.
// Optional TCNT is present only when JK_TOGGLE_CNT_EN is defined.
interface jk_reg_bank_if #(parameter int WIDTH = 4);
  import jk_pkg::*;

  // Level-sensitive controls, no handshake: inputs are sampled on every rising
  // CLK edge and Q/Qbar/SOUT/CHG are valid throughout the following cycle.
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] D;
  logic             SIN;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             SOUT;
  logic             CHG;
`ifdef JK_TOGGLE_CNT_EN
  logic [TCNT_W-1:0] TCNT;

  modport master (output EN, MODE, J, K, D, SIN, input Q, Qbar, SOUT, CHG, TCNT);
  modport slave  (input EN, MODE, J, K, D, SIN, output Q, Qbar, SOUT, CHG, TCNT);
`else
  modport master (output EN, MODE, J, K, D, SIN, input Q, Qbar, SOUT, CHG);
  modport slave  (input EN, MODE, J, K, D, SIN, output Q, Qbar, SOUT, CHG);
`endif

endinterface

// File: rtl/jk_reg_bank_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset to RST_BIT and clock enable.
module jk_cell
  import jk_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic J,
  input  logic K,
  input  logic RST_BIT,
  output logic Q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= RST_BIT;
    end else if (EN) begin
      Q <= jk_next(Q, J, K);
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank with JK, parallel-load and shift modes.
// Optional toggle counter output TCNT when JK_TOGGLE_CNT_EN is defined.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input logic          CLK,
  input logic          RST,
  jk_reg_bank_if.slave bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] eff_j;
  logic [WIDTH-1:0] eff_k;
  logic [WIDTH-1:0] q_next;
  logic             chg_q;

  // Non-JK modes steer every cell to a target bit via J=d, K=~d, so only
  // the inputs belonging to the selected mode ever reach the cells.
  always_comb begin
    tgt   = q;
    eff_j = bus.J;
    eff_k = bus.K;
    case (bus.MODE)
      MODE_LOAD: tgt = bus.D;
      MODE_SHL:  tgt = {q[WIDTH-2:0], bus.SIN};
      MODE_SHR:  tgt = {bus.SIN, q[WIDTH-1:1]};
      default:   tgt = q;
    endcase
    if (bus.MODE != MODE_JK) begin
      eff_j = tgt;
      eff_k = ~tgt;
    end
    for (int i = 0; i < WIDTH; i++) begin
      q_next[i] = jk_next(q[i], eff_j[i], eff_k[i]);
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (bus.EN),
      .J       (eff_j[gi]),
      .K       (eff_k[gi]),
      .RST_BIT (RST_VAL[gi]),
      .Q       (q[gi])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      chg_q <= 1'b0;
    end else if (bus.EN) begin
      chg_q <= (q_next != q);
    end else begin
      chg_q <= 1'b0;
    end
  end

`ifdef JK_TOGGLE_CNT_EN
  logic [TCNT_W-1:0] tcnt_q;

  // Counts edges that set CHG, saturating rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcnt_q <= '0;
    end else if (bus.EN && (q_next != q) && (tcnt_q != {TCNT_W{1'b1}})) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  assign bus.TCNT = tcnt_q;
`endif

  assign bus.Q    = q;
  assign bus.Qbar = ~q;
  assign bus.SOUT = (bus.MODE == MODE_SHL) ? q[WIDTH-1] : q[0];
  assign bus.CHG  = chg_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed-vector bench for jk_reg_bank (WIDTH=4, RST_VAL=4'b1010) with a queued scoreboard.
// Define JK_TOGGLE_CNT_EN to also exercise the TCNT counter.
module tb_jk_reg_bank;
  import jk_pkg::*;

  localparam int W = 4;
  localparam int E = 2 * W + 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  jk_reg_bank_if #(.WIDTH(W)) tb_if ();

  jk_reg_bank #(.WIDTH(W), .RST_VAL(4'b1010)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (tb_if.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [E-1:0] exp_q[$];
  int           id_q[$];
  int           n_vec;
  int           n_err;
  int           vec_id;

  // ---------------- driver tasks ----------------
  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  // Drives one vector at the falling edge and queues the response expected
  // after the next rising edge: {Q, Qbar, SOUT, CHG}.
  task automatic apply(input logic rst_v, input logic en_v, input logic [1:0] mode_v,
                       input logic [3:0] j_v, input logic [3:0] k_v, input logic [3:0] d_v,
                       input logic sin_v, input logic [3:0] exp_qv, input logic exp_chg);
    logic exp_sout;
    @(negedge clk);
    rst         = rst_v;
    tb_if.EN    = en_v;
    tb_if.MODE  = mode_v;
    tb_if.J     = j_v;
    tb_if.K     = k_v;
    tb_if.D     = d_v;
    tb_if.SIN   = sin_v;
    exp_sout    = (mode_v == MODE_SHL) ? exp_qv[3] : exp_qv[0];
    exp_q.push_back({exp_qv, ~exp_qv, exp_sout, exp_chg});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
      id_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [E-1:0] got;
    logic [E-1:0] exp;
    int           id;
    #2;
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      id  = id_q.pop_front();
      got = {tb_if.Q, tb_if.Qbar, tb_if.SOUT, tb_if.CHG};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL vec%0d: Q/Qbar/SOUT/CHG got %b/%b/%b/%b required %b/%b/%b/%b",
                 id, got[9:6], got[5:2], got[1], got[0], exp[9:6], exp[5:2], exp[1], exp[0]);
      end
    end
  end

`ifdef JK_TOGGLE_CNT_EN
  task automatic check_tcnt(input string name, input logic [TCNT_W-1:0] exp_cnt);
    drain();
    n_vec++;
    if (tb_if.TCNT !== exp_cnt) begin
      n_err++;
      $display("FAIL %s: TCNT got %h required %h", name, tb_if.TCNT, exp_cnt);
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    n_vec      = 0;
    n_err      = 0;
    vec_id     = 0;
    rst        = 1'b1;
    tb_if.EN   = 1'b0;
    tb_if.MODE = MODE_JK;
    tb_if.J    = '0;
    tb_if.K    = '0;
    tb_if.D    = '0;
    tb_if.SIN  = 1'b0;

    //     rst  en   mode       J        K        D        SIN   expQ     CHG
    // Reset beats a concurrent all-toggle request.
    apply(1'b1, 1'b1, MODE_JK,   4'hF,    4'hF,    rnd4(),  1'b1, 4'b1010, 1'b0);
    apply(1'b1, 1'b1, MODE_JK,   4'hF,    4'hF,    rnd4(),  1'b1, 4'b1010, 1'b0);
    // Per-bit hold / clear / set / toggle from 1010.
    apply(1'b0, 1'b1, MODE_JK,   4'b0011, 4'b0101, rnd4(),  1'b0, 4'b1011, 1'b1);
    apply(1'b0, 1'b0, MODE_JK,   4'b0011, 4'b0101, rnd4(),  1'b0, 4'b1011, 1'b0);
    apply(1'b0, 1'b1, MODE_JK,   4'hF,    4'hF,    rnd4(),  1'b0, 4'b0100, 1'b1);
    apply(1'b0, 1'b1, MODE_JK,   4'hF,    4'hF,    rnd4(),  1'b0, 4'b1011, 1'b1);
    apply(1'b0, 1'b1, MODE_JK,   4'h0,    4'h0,    rnd4(),  1'b1, 4'b1011, 1'b0);
    // Load, shift left twice, shift right once.
    apply(1'b0, 1'b1, MODE_LOAD, rnd4(),  rnd4(),  4'b0111, 1'b1, 4'b0111, 1'b1);
    apply(1'b0, 1'b1, MODE_SHL,  rnd4(),  rnd4(),  rnd4(),  1'b1, 4'b1111, 1'b1);
    apply(1'b0, 1'b1, MODE_SHL,  rnd4(),  rnd4(),  rnd4(),  1'b0, 4'b1110, 1'b1);
    apply(1'b0, 1'b1, MODE_SHR,  rnd4(),  rnd4(),  rnd4(),  1'b0, 4'b0111, 1'b1);
    // Mid-shift reset discards the shift, then shifting resumes from RST_VAL.
    apply(1'b0, 1'b1, MODE_SHL,  rnd4(),  rnd4(),  rnd4(),  1'b1, 4'b1111, 1'b1);
    apply(1'b1, 1'b1, MODE_SHL,  rnd4(),  rnd4(),  rnd4(),  1'b1, 4'b1010, 1'b0);
    apply(1'b0, 1'b1, MODE_SHL,  rnd4(),  rnd4(),  rnd4(),  1'b1, 4'b0101, 1'b1);
    // Load of the value already held: no change reported.
    apply(1'b0, 1'b1, MODE_LOAD, rnd4(),  rnd4(),  4'b0101, 1'b0, 4'b0101, 1'b0);
    // Reset acts while EN is low.
    apply(1'b1, 1'b0, MODE_LOAD, rnd4(),  rnd4(),  rnd4(),  1'b0, 4'b1010, 1'b0);
    // Shift right with SIN=1, then EN low holds in a shift mode.
    apply(1'b0, 1'b1, MODE_SHR,  rnd4(),  rnd4(),  rnd4(),  1'b1, 4'b1101, 1'b1);
    apply(1'b0, 1'b0, MODE_SHR,  rnd4(),  rnd4(),  rnd4(),  1'b0, 4'b1101, 1'b0);
    // Mixed JK from 1101: bit3 clear, bit2 toggle, bit1 set, bit0 hold.
    apply(1'b0, 1'b1, MODE_JK,   4'b0110, 4'b1100, rnd4(),  1'b0, 4'b0011, 1'b1);
    drain();

`ifdef JK_TOGGLE_CNT_EN
    apply(1'b1, 1'b1, MODE_JK,   4'h0,    4'h0,    4'h0,    1'b0, 4'b1010, 1'b0);
    check_tcnt("tcnt_reset", 16'h0000);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, MODE_JK, 4'hF, 4'hF, 4'h0, 1'b0, (i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, MODE_JK, 4'h0, 4'h0, 4'h0, 1'b0, 4'b0101, 1'b0);
    end
    check_tcnt("tcnt_count5", 16'd5);
    apply(1'b1, 1'b1, MODE_JK,   4'hF,    4'hF,    4'h0,    1'b0, 4'b1010, 1'b0);
    check_tcnt("tcnt_clear", 16'h0000);
    @(negedge clk);
    force dut.tcnt_q = 16'hFFFE;
    #1;
    release dut.tcnt_q;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, MODE_JK, 4'hF, 4'hF, 4'h0, 1'b0, (i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b1);
    end
    check_tcnt("tcnt_saturate", 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
